// File: rtl/rr_xbar_router_pkg.sv
// router_pkg: shared constants and flit helpers for the rr_xbar_router crossbar.
package router_pkg;
  localparam int CNT_W = 16;
  localparam int FLIT_MAX = 1024;
  function automatic int dest_w(input int lanes);
    return $clog2(lanes);
  endfunction
  function automatic int unsigned dest_of(input logic [FLIT_MAX-1:0] flit, input int data, input int dw);
    return 32'(flit >> (data - dw)) & ((32'd1 << dw) - 32'd1);
  endfunction
endpackage

// File: rtl/rr_xbar_router_fifo.sv
// router_fifo: synchronous first-word-fall-through FIFO, depth 2**ADDR.
module router_fifo #(
  parameter int DATA = 64,
  parameter int ADDR = 5
)(
  input  logic            clK,
  input  logic            rsT,
  input  logic            push,
  input  logic            pop,
  input  logic [DATA-1:0] din,
  output logic [DATA-1:0] dout,
  output logic            full,
  output logic            empty
);
  logic [DATA-1:0] mem [2**ADDR];
  logic [ADDR:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {ADDR{1'b0}}};
  assign dout = mem[rp[ADDR-1:0]];
  always_ff @(posedge clK)
    if (do_push) mem[wp[ADDR-1:0]] <= din;
  always_ff @(posedge clK) begin
    if (rsT) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (ADDR+1)'(do_push);
      rp <= rp + (ADDR+1)'(do_pop);
    end
  end
endmodule

// File: rtl/rr_xbar_router.sv
// rr_xbar_router: LANESxLANES crossbar, per-input FIFOs, per-output round-robin arbiter and register stage.
// Optional ROUTER_DROP_CNT_EN adds saturating per-input drop counters on drop_CNT.
module rr_xbar_router import router_pkg::*; #(
  parameter int DATA  = 64,
  parameter int ADDR  = 5,
  parameter int LANES = 4
)(
  input  logic                  clK,
  input  logic                  rsT,
  input  logic [LANES-1:0]      WR,
  input  logic [LANES*DATA-1:0] IN,
  output logic [LANES-1:0]      in_BUSY,
  output logic [LANES*DATA-1:0] OUT,
  output logic [LANES-1:0]      out_VLD,
  input  logic [LANES-1:0]      RD,
  output logic [LANES-1:0]      out_BUSY
`ifdef ROUTER_DROP_CNT_EN
  ,
  output logic [LANES*CNT_W-1:0] drop_CNT
`endif
);
  localparam int DEST_W = dest_w(LANES);
  logic [LANES-1:0] empty, pop;
  logic [DATA-1:0] head [LANES];
  logic [LANES-1:0] req [LANES];
  logic [LANES-1:0] gsel [LANES];
  assign out_BUSY = out_VLD & ~RD;
  for (genvar i = 0; i < LANES; i++) begin : g_in
    router_fifo #(.DATA(DATA), .ADDR(ADDR)) u_fifo (
      .clK(clK), .rsT(rsT), .push(WR[i] & ~in_BUSY[i]), .pop(pop[i]),
      .din(IN[i*DATA +: DATA]), .dout(head[i]), .full(in_BUSY[i]), .empty(empty[i])
    );
    assign req[i] = empty[i] ? '0 : LANES'(1) << dest_of(FLIT_MAX'(head[i]), DATA, DEST_W);
  end
  always_comb begin
    pop = '0;
    for (int o = 0; o < LANES; o++) pop |= gsel[o];
  end
  for (genvar o = 0; o < LANES; o++) begin : g_out
    logic hit, vld, free;
    logic [DEST_W-1:0] ptr, idx;
    logic [DATA-1:0] q;
    assign free = ~vld | RD[o];
    // Scan from the far end so the requester nearest ptr is the one left in idx.
    always_comb begin
      hit = 1'b0;
      idx = ptr;
      for (int k = LANES - 1; k >= 0; k--)
        if (req[ptr + DEST_W'(k)][o]) begin
          hit = 1'b1;
          idx = ptr + DEST_W'(k);
        end
    end
    assign gsel[o] = (hit && free) ? LANES'(1) << idx : '0;
    always_ff @(posedge clK) begin
      if (rsT) begin
        vld <= 1'b0;
        q <= '0;
        ptr <= '0;
      end else if (free) begin
        vld <= hit;
        if (hit) begin
          q <= head[idx];
          ptr <= idx + DEST_W'(1);
        end
      end
    end
    assign OUT[o*DATA +: DATA] = q;
    assign out_VLD[o] = vld;
  end
`ifdef ROUTER_DROP_CNT_EN
  for (genvar i = 0; i < LANES; i++) begin : g_drop
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clK) begin
      if (rsT) cnt <= '0;
      else if (WR[i] && in_BUSY[i] && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
    assign drop_CNT[i*CNT_W +: CNT_W] = cnt;
  end
`else
`endif
endmodule

// File: tb/tb_rr_xbar_router.sv
// tb_rr_xbar_router: queue-based reference model plus scoreboard monitor for rr_xbar_router.
module tb_rr_xbar_router;
  localparam int L = 4, D = 64, A = 5, DEPTH = 32, DW = 2;
  logic clK = 1'b0, rsT = 1'b1;
  logic [L-1:0] WR = '0, RD = '0;
  logic [L*D-1:0] IN = '0;
  logic [L-1:0] in_BUSY, out_VLD, out_BUSY;
  logic [L*D-1:0] OUT;
`ifdef ROUTER_DROP_CNT_EN
  logic [L*16-1:0] drop_CNT;
`endif
  rr_xbar_router #(.DATA(D), .ADDR(A), .LANES(L)) dut (
    .clK(clK), .rsT(rsT), .WR(WR), .IN(IN), .in_BUSY(in_BUSY), .OUT(OUT),
    .out_VLD(out_VLD), .RD(RD), .out_BUSY(out_BUSY)
`ifdef ROUTER_DROP_CNT_EN
    , .drop_CNT(drop_CNT)
`endif
  );
  always #5 clK = ~clK;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [D-1:0] act, input logic [D-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [D-1:0] mk(input int dst, input logic [D-1:0] p);
    logic [D-1:0] f;
    f = p;
    f[D-1 -: DW] = DW'(dst);
    return f;
  endfunction

  // Reference model: each input is a queue, each output a stage with a rotating priority.
  logic [D-1:0] mq [L][$];
  logic [D-1:0] expq [L][$];
  bit mv [L];
  int ptr [L], hd [L], mdrop [L];
  bit fb [L];
  int g, c;
  always @(posedge clK) begin
    if (rsT) begin
      for (int i = 0; i < L; i++) begin
        mq[i].delete(); expq[i].delete();
        mv[i] = 0; ptr[i] = 0; mdrop[i] = 0;
      end
    end else begin
      for (int i = 0; i < L; i++) begin
        hd[i] = mq[i].size() > 0 ? int'(mq[i][0][D-1 -: DW]) : -1;
        fb[i] = mq[i].size() == DEPTH;
      end
      for (int o = 0; o < L; o++)
        if (!mv[o] || RD[o]) begin
          g = -1;
          for (int k = 0; k < L; k++) begin
            c = (ptr[o] + k) % L;
            if (g < 0 && hd[c] == o) g = c;
          end
          if (g >= 0) begin
            expq[o].push_back(mq[g].pop_front());
            mv[o] = 1;
            ptr[o] = (g + 1) % L;
          end else mv[o] = 0;
        end
      for (int i = 0; i < L; i++)
        if (WR[i]) begin
          if (!fb[i]) mq[i].push_back(IN[i*D +: D]);
          else if (mdrop[i] < 65535) mdrop[i]++;
        end
    end
  end

  // Monitor: every newly presented flit is popped from the scoreboard and compared.
  logic [L-1:0] v_s, rd_s, fullv;
  logic r_s;
  int hs [L];
  initial for (int o = 0; o < L; o++) hs[o] = 0;
  always @(posedge clK) begin
    v_s = out_VLD; rd_s = RD; r_s = rsT;
    #1;
    for (int o = 0; o < L; o++) begin
      chk($sformatf("out_VLD[%0d]", o), D'(out_VLD[o]), D'(mv[o]));
      if (r_s) chk($sformatf("reset OUT%0d", o), OUT[o*D +: D], '0);
      else begin
        if (v_s[o] && rd_s[o]) hs[o]++;
        if ((!v_s[o] || rd_s[o]) && out_VLD[o]) begin
          if (expq[o].size() == 0) chk($sformatf("unexpected flit OUT%0d", o), D'(1), D'(0));
          else chk($sformatf("flit OUT%0d", o), OUT[o*D +: D], expq[o].pop_front());
        end
      end
      fullv[o] = mq[o].size() == DEPTH;
    end
    chk("in_BUSY", D'(in_BUSY), D'(fullv));
  end

  task automatic cyc(input logic [L-1:0] wr, input logic [L*D-1:0] din, input logic [L-1:0] rd);
    WR = wr; IN = din; RD = rd;
    @(negedge clK);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  logic [L*D-1:0] dv;
  int h0;
  initial begin
    rsT = 1'b1;
    repeat (3) @(negedge clK);
    rsT = 1'b0;
    chk("reset in_BUSY", D'(in_BUSY), '0);
    // single flit, two-edge latency
    dv = '0; dv[0 +: D] = mk(2, 64'hAB);
    cyc(4'b0001, dv, 4'b0000);
    chk("single vld after 1 edge", D'(out_VLD), '0);
    cyc('0, '0, '0);
    chk("single vld after 2 edges", D'(out_VLD), D'(4'b0100));
    chk("single OUT2", OUT[2*D +: D], mk(2, 64'hAB));
    cyc('0, '0, 4'b0100);
    cyc('0, '0, '0);
    // contention on output 1, two rounds
    for (int r = 0; r < 2; r++) begin
      dv = '0;
      for (int i = 0; i < L; i++) dv[i*D +: D] = mk(1, 64'h100 + i);
      cyc(4'b1011, dv, 4'b0010);
      cyc('0, '0, 4'b0010); chk("contend grant 0", OUT[D +: D], mk(1, 64'h100));
      cyc('0, '0, 4'b0010); chk("contend grant 1", OUT[D +: D], mk(1, 64'h101));
      cyc('0, '0, 4'b0010); chk("contend grant 3", OUT[D +: D], mk(1, 64'h103));
      cyc('0, '0, 4'b0010); chk("contend drained", D'(out_VLD[1]), '0);
    end
    // backpressure on output 0
    dv = '0; dv[0 +: D] = mk(0, 64'h500);
    cyc(4'b0001, dv, '0);
    cyc('0, '0, '0);
    for (int k = 0; k < DEPTH + 1; k++) begin
      dv = '0; dv[0 +: D] = mk(0, 64'h600 + k);
      cyc(4'b0001, dv, '0);
    end
    chk("bp in_BUSY0", D'(in_BUSY[0]), D'(1));
    chk("bp out_BUSY0", D'(out_BUSY[0]), D'(1));
`ifdef ROUTER_DROP_CNT_EN
    chk("bp drop_CNT0", D'(drop_CNT[15:0]), D'(1));
`endif
    h0 = hs[0];
    repeat (40) cyc('0, '0, 4'b0001);
    chk("bp delivered", D'(hs[0] - h0), D'(DEPTH + 1));
    chk("bp in_BUSY0 released", D'(in_BUSY[0]), '0);
    // parallel permutation
    dv = '0;
    for (int i = 0; i < L; i++) dv[i*D +: D] = mk(L - 1 - i, 64'h700 + i);
    cyc(4'hF, dv, 4'hF);
    cyc('0, '0, 4'hF);
    chk("parallel all valid", D'(out_VLD), D'(4'hF));
    cyc('0, '0, 4'hF);
    chk("parallel drained", D'(out_VLD), '0);
    // reset mid-traffic
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < L; i++) dv[i*D +: D] = mk(int'($urandom_range(0, L - 1)), {$urandom, $urandom});
      cyc(4'hF, dv, '0);
    end
    chk("mid-traffic vld set", D'(out_VLD != '0), D'(1));
    rsT = 1'b1;
    cyc(4'hF, dv, 4'hF);
    rsT = 1'b0;
    chk("mid reset out_VLD", D'(out_VLD), '0);
    chk("mid reset in_BUSY", D'(in_BUSY), '0);
    chk("mid reset OUT", OUT[D-1:0] | OUT[2*D-1:D] | OUT[3*D-1:2*D] | OUT[4*D-1:3*D], '0);
    repeat (10) cyc('0, '0, 4'hF);
    chk("no stale flit", D'(out_VLD), '0);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [L-1:0] rd;
      for (int i = 0; i < L; i++) begin
        dv[i*D +: D] = {$urandom, $urandom};
        rd[i] = $urandom_range(0, 3) != 0;
      end
      cyc(L'($urandom), dv, rd);
    end
    repeat (200) cyc('0, '0, 4'hF);
    for (int o = 0; o < L; o++) chk($sformatf("drain expq%0d", o), D'(expq[o].size()), '0);
    chk("drain out_VLD", D'(out_VLD), '0);
`ifdef ROUTER_DROP_CNT_EN
    // saturation of the drop counter on input 2
    rsT = 1'b1; cyc('0, '0, '0); rsT = 1'b0;
    dv = '0; dv[2*D +: D] = mk(0, 64'h900);
    repeat (70000 + DEPTH + 2) cyc(4'b0100, dv, '0);
    chk("sat drop_CNT2", D'(drop_CNT[47:32]), D'(16'hFFFF));
    chk("sat model", D'(mdrop[2]), D'(65535));
    repeat (5) cyc(4'b0100, dv, '0);
    chk("sat no wrap", D'(drop_CNT[47:32]), D'(16'hFFFF));
    chk("sat other lanes", D'(drop_CNT[15:0] | drop_CNT[31:16] | drop_CNT[63:48]), '0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
